// File: rtl/cu_pkg.sv
// Shared constants and types for the instruction-cycle control unit:
// fetch/indirect step indices, default geometry and the strobe bundle.
package cu_pkg;

  localparam int DEF_OPW        = 3;
  localparam int DEF_NT         = 16;
  localparam int DEF_EXEC_START = 10;

  localparam int T_PC2AR    = 0;
  localparam int T_LD_AR    = 1;
  localparam int T_FETCH_RD = 2;
  localparam int T_MEM2IR   = 3;
  localparam int T_LD_IR    = 4;
  localparam int T_DECODE   = 5;
  localparam int T_LD_I     = 6;
  localparam int T_IND_RD   = 7;
  localparam int T_IND_BUS  = 8;
  localparam int T_IND_LDAR = 9;

  typedef struct packed {
    logic x2;
    logic x5;
    logic x7;
    logic read;
    logic ld_ar;
    logic ld_ir;
    logic ld_i;
    logic inr_pc;
  } strobe_t;

  // The all-ones opcode is the I/O instruction, which never goes indirect.
  function automatic int io_op_idx(input int opw);
    return (1 << opw) - 1;
  endfunction

endpackage

// File: rtl/cu_opdec.sv
// Opcode decoder: OPW-bit opcode to 2**OPW one-hot lines, purely combinational.
module cu_opdec #(
  parameter int OPW = 3
) (
  input  logic [OPW-1:0]        op,
  output logic [(1<<OPW)-1:0]   D
);

  always_comb begin
    D     = '0;
    D[op] = 1'b1;
  end

endmodule

// File: rtl/cu_seq_ctrl.sv
// Instruction-cycle control unit: step counter with read stall, I-flag latch,
// indirect bypass and execute completion/timeout, plus fetch/indirect strobes.
module cu_seq_ctrl
  import cu_pkg::*;
#(
  parameter int OPW        = DEF_OPW,
  parameter int NT         = DEF_NT,
  parameter int EXEC_START = DEF_EXEC_START
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [OPW-1:0]        op,
  input  logic                  i_bit,
  input  logic                  mem_ready,
  input  logic                  exec_done,
  output logic [NT-1:0]         T,
  output logic [$clog2(NT)-1:0] sc,
  output logic [(1<<OPW)-1:0]   D,
  output logic                  x2,
  output logic                  x5,
  output logic                  x7,
  output logic                  read,
  output logic                  ld_ar,
  output logic                  ld_ir,
  output logic                  ld_i,
  output logic                  inr_pc,
  output logic                  i_reg,
  output logic                  exec_en,
  output logic                  instr_done,
  output logic                  exec_timeout
);

  localparam int              SCW     = $clog2(NT);
  localparam int              IO_IDX  = io_op_idx(OPW);
  localparam logic [SCW-1:0]  SC_LAST = SCW'(NT - 1);
  localparam logic [SCW-1:0]  SC_EXEC = SCW'(EXEC_START);
  localparam logic [SCW-1:0]  SC_LD_I = SCW'(T_LD_I);
  localparam logic [SCW-1:0]  SC_ONE  = SCW'(1);

  logic    ind_act;
  logic    stall;
  logic    bypass;
  strobe_t stb;

  cu_opdec #(.OPW(OPW)) u_opdec (
    .op (op),
    .D  (D)
  );

  always_comb begin
    T     = '0;
    T[sc] = 1'b1;
  end

  assign ind_act = i_reg & ~D[IO_IDX];
  assign exec_en = (sc >= SC_EXEC);
  assign bypass  = ~i_bit | D[IO_IDX];

  // Indirect strobes are additionally gated so a bypassed path can never pulse them.
  always_comb begin
    stb        = '0;
    stb.x2     = T[T_PC2AR];
    stb.ld_ar  = T[T_LD_AR] | T[T_LD_I] | (T[T_IND_LDAR] & ind_act);
    stb.read   = T[T_FETCH_RD] | (T[T_IND_RD] & ind_act);
    stb.x7     = T[T_MEM2IR] | (T[T_IND_BUS] & ind_act);
    stb.inr_pc = T[T_LD_IR];
    stb.ld_ir  = T[T_LD_IR];
    stb.x5     = T[T_DECODE];
    stb.ld_i   = T[T_LD_I];
  end

  assign x2     = stb.x2;
  assign x5     = stb.x5;
  assign x7     = stb.x7;
  assign read   = stb.read;
  assign ld_ar  = stb.ld_ar;
  assign ld_ir  = stb.ld_ir;
  assign ld_i   = stb.ld_i;
  assign inr_pc = stb.inr_pc;

  assign stall  = stb.read & ~mem_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      sc           <= '0;
      i_reg        <= 1'b0;
      instr_done   <= 1'b0;
      exec_timeout <= 1'b0;
    end else begin
      instr_done   <= 1'b0;
      exec_timeout <= 1'b0;
      if (!stall) begin
        if (exec_en) begin
          // Completion wins over timeout when both land on the last step.
          if (exec_done || (sc == SC_LAST)) begin
            sc <= '0;
          end else begin
            sc <= sc + SC_ONE;
          end
          instr_done   <= exec_done;
          exec_timeout <= ~exec_done & (sc == SC_LAST);
        end else if (sc == SC_LD_I) begin
          i_reg <= i_bit;
          sc    <= bypass ? SC_EXEC : sc + SC_ONE;
        end else begin
          sc <= sc + SC_ONE;
        end
      end
    end
  end

  a_t_onehot:   assert property (@(posedge clk) disable iff (rst) $onehot(T));
  a_d_onehot:   assert property (@(posedge clk) disable iff (rst) $onehot(D));
  a_no_ex_read: assert property (@(posedge clk) disable iff (rst) !(read && exec_en));

endmodule

// File: doc/cu_seq_ctrl.md
Name: cu_seq_ctrl

Overview:
- Parametrised instruction-cycle control unit: timing sequencer, opcode decoder and control-signal generator.
- Covers the fetch, indirect and execute phases.
- Differences from the fixed 16-step, free-running generation:
  - configurable opcode width and step count;
  - synchronous reset;
  - memory-ready stall;
  - I-flag latch;
  - I/O-opcode indirect bypass;
  - datapath-driven execute completion with timeout.
- Sits between IR/I flip-flop and the datapath mux/load strobes.

Parameters:
OPW, 3, opcode width; the decoder produces 2**OPW one-hot lines.
NT, 16, number of timing steps; legal range 12..64.
EXEC_START, 10, first execute step; legal range 10..NT-2.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
op  in  OPW  opcode field from IR, valid from T5 onward
i_bit  in  1  indirect bit from IR, sampled at T6
mem_ready  in  1  memory read complete; low stalls a Read step
exec_done  in  1  datapath finished execute phase
T  out  NT  one-hot timing step, bit 0 = T0
sc  out  clog2(NT)  binary step count, equal to the index of the set T bit
D  out  2**OPW  one-hot decoded opcode, combinational from op
x2, x5, x7  out  1 each  bus-select strobes
read  out  1  memory read request
ld_ar, ld_ir, ld_i, inr_pc  out  1 each  register load/increment strobes
i_reg  out  1  latched indirect flag
exec_en  out  1  high throughout the execute phase
instr_done  out  1  one-cycle pulse when an instruction completes normally
exec_timeout  out  1  one-cycle pulse when execute is aborted at step NT-1

Behaviour:
- Reset (synchronous, rst high at clk edge):
  - sc=0, T=1 at bit 0, i_reg=0.
  - instr_done=0, exec_timeout=0.
  - rst overrides every other input, including mid-stall and mid-execute.
- Step advance:
  - sc increments by 1 each clk unless stalled.
  - T is a decode of sc; T and sc change on the same edge.
- Stall:
  - stall = read & ~mem_ready.
  - While stalled, sc/T hold and all strobes for that step stay asserted.
  - Only Read steps (T2, T7) can stall.
- Fetch strobes (combinational from T):
  - T0: x2
  - T1: ld_ar
  - T2: read
  - T3: x7
  - T4: inr_pc, ld_ir
  - T5: x5
  - T6: ld_i, ld_ar; i_reg <= i_bit at the T6 edge.
- Indirect phase (T7..T9) is active when i_reg=1 and D[2**OPW-1]=0:
  - T7: read
  - T8: x7
  - T9: ld_ar
- Bypass: after T6, sc jumps directly to EXEC_START when either i_bit=0 at the T6 edge or D[2**OPW-1]=1. Strobes for T7..T9 are never asserted on the bypass path.
- Execute phase:
  - exec_en=1 while sc >= EXEC_START.
  - exec_done=1 at a clk edge in execute: sc<=0 and instr_done pulses high in the following cycle. Minimum execute length is 1 cycle.
  - exec_done outside execute is ignored.
- Timeout: if sc=NT-1 with exec_done=0, the next edge wraps sc to 0 and exec_timeout pulses for one cycle.
- Simultaneous exec_done and sc=NT-1: counts as normal completion. instr_done pulses; exec_timeout does not.
- Pulse timing: instr_done and exec_timeout are registered outputs, each high exactly one cycle.
- Invariants:
  - exactly one T bit is set at all times;
  - D is one-hot for every op value;
  - read is never asserted during execute (the datapath owns memory then).

Decomposition:
- Shared package cu_pkg:
  - step index constants for the fetch and indirect phases (T_PC2AR=0 … T_IND_LDAR=9);
  - default OPW/NT/EXEC_START;
  - the IO opcode index function (2**OPW-1).
- One sub-module: cu_opdec, a parametrised OPW-to-one-hot decoder.
- Sequencer and strobe logic stay in the top module.

Test Plan:
1. Direct, non-IO op, no stalls:
   - Stimulus: rst for 2 cycles, op=3'b010, i_bit=0, mem_ready=1, exec_done asserted at sc=12.
   - Response: strobes T0..T6 as listed; sc goes 6->10; instr_done one cycle after the exec_done edge; sc=0.
2. Indirect, non-IO op:
   - Stimulus: i_bit=1, op=3'b001, exec_done at sc=10.
   - Response: read at T7, x7 at T8, ld_ar at T9; i_reg=1; sc sequence 0..10 then 0.
3. IO op with indirect bit set:
   - Stimulus: op=3'b111, i_bit=1.
   - Response: sc goes 6->10; read/x7 never asserted after T6.
4. Fetch-read stall:
   - Stimulus: mem_ready=0 for 3 cycles at T2.
   - Response: sc=2 and read=1 held for 4 cycles total; T3 follows in the cycle after mem_ready rises.
5. Execute timeout:
   - Stimulus: exec_done held 0.
   - Response: sc reaches 15; next cycle sc=0 and exec_timeout=1 for exactly one cycle; instr_done stays 0.
6. Reset mid-operation and parameter variant:
   - Stimulus: rst at sc=8 during the indirect phase.
   - Response: next cycle sc=0, T=1, i_reg=0, no strobes other than x2.
   - Repeat scenario 1 with NT=32, OPW=4, EXEC_START=12: timeout occurs at sc=31, and D[15] triggers the bypass.
